// File: rtl/ins_cycle_pkg.sv
// Shared encodings for the accumulator-processor control unit: opcodes, FSM states
// and accumulator source selects.
package ins_cycle_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] ST_START    = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_LOAD     = 4'd3;
    localparam logic [3:0] ST_STORE    = 4'd4;
    localparam logic [3:0] ST_ADD      = 4'd5;
    localparam logic [3:0] ST_SUB      = 4'd6;
    localparam logic [3:0] ST_INPUT    = 4'd7;
    localparam logic [3:0] ST_JZ       = 4'd8;
    localparam logic [3:0] ST_JPOS     = 4'd9;
    localparam logic [3:0] ST_HALT     = 4'd10;
    localparam logic [3:0] ST_STEPWAIT = 4'd11;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    // Execute state reached from DECODE for a given opcode.
    function automatic logic [3:0] exec_state(input logic [2:0] op);
        case (op)
            OP_LOAD:  exec_state = ST_LOAD;
            OP_STORE: exec_state = ST_STORE;
            OP_ADD:   exec_state = ST_ADD;
            OP_SUB:   exec_state = ST_SUB;
            OP_INPUT: exec_state = ST_INPUT;
            OP_JZ:    exec_state = ST_JZ;
            OP_JPOS:  exec_state = ST_JPOS;
            default:  exec_state = ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/ins_cycle_ctrl_if.sv
// Control/status bundle between the control FSM (master) and the processor datapath (slave).
interface ins_cycle_ctrl_if;

    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       Enter;
    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic [1:0] Asel;
    logic       Sub;
    logic       Halted;
    logic [3:0] State;

    modport master (
        input  IR, Aeq0, Apos, Enter,
        output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Asel, Sub, Halted, State
    );

    modport slave (
        output IR, Aeq0, Apos, Enter,
        input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Asel, Sub, Halted, State
    );

endinterface

// File: rtl/ins_cycle_ctrl_edge_rise.sv
// Registered rising-edge detector: rise is high in the first cycle d is seen high.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/ins_cycle_ctrl.sv
// Fetch/decode/execute control FSM for the 8-bit accumulator processor.
// Optional feature: define SINGLE_STEP_EN to add the Step input and the STEPWAIT state.
module ins_cycle_ctrl
    import ins_cycle_pkg::*;
#(
    parameter bit ENTER_EDGE = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
`ifdef SINGLE_STEP_EN
    input  logic              Step,
`endif
    ins_cycle_ctrl_if.master  bus
);

    logic [3:0] state, state_nxt, fetch_tgt;
    logic       enter_rise, enter_done;
    logic       irload, pcload, jmpmux, meminst, memwr, aload, sub, halted;
    logic [1:0] asel;

    edge_rise u_enter_edge (
        .clk   (Clock),
        .rst_n (Reset),
        .d     (bus.Enter),
        .rise  (enter_rise)
    );

    assign enter_done = ENTER_EDGE ? enter_rise : bus.Enter;

`ifdef SINGLE_STEP_EN
    logic step_rise;

    edge_rise u_step_edge (
        .clk   (Clock),
        .rst_n (Reset),
        .d     (Step),
        .rise  (step_rise)
    );

    // Every return to FETCH is parked until the operator steps.
    assign fetch_tgt = ST_STEPWAIT;
`else
    assign fetch_tgt = ST_FETCH;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_START;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_START;
        irload    = 1'b0;
        pcload    = 1'b0;
        jmpmux    = 1'b0;
        meminst   = 1'b0;
        memwr     = 1'b0;
        aload     = 1'b0;
        asel      = ASEL_ALU;
        sub       = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_START: state_nxt = fetch_tgt;
            ST_FETCH: begin
                irload    = 1'b1;
                pcload    = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                meminst   = 1'b1;
                state_nxt = exec_state(bus.IR);
            end
            ST_LOAD: begin
                meminst   = 1'b1;
                asel      = ASEL_MEM;
                aload     = 1'b1;
                state_nxt = fetch_tgt;
            end
            ST_STORE: begin
                meminst   = 1'b1;
                memwr     = 1'b1;
                state_nxt = fetch_tgt;
            end
            ST_ADD, ST_SUB: begin
                meminst   = 1'b1;
                aload     = 1'b1;
                sub       = (state == ST_SUB);
                state_nxt = fetch_tgt;
            end
            ST_INPUT: begin
                asel      = ASEL_IN;
                aload     = enter_done;
                state_nxt = enter_done ? fetch_tgt : ST_INPUT;
            end
            // Jumps are Mealy on the accumulator status so the branch resolves in one cycle.
            ST_JZ: begin
                jmpmux    = 1'b1;
                pcload    = bus.Aeq0;
                state_nxt = fetch_tgt;
            end
            ST_JPOS: begin
                jmpmux    = 1'b1;
                pcload    = bus.Apos;
                state_nxt = fetch_tgt;
            end
            ST_HALT: begin
                halted    = 1'b1;
                state_nxt = ST_HALT;
            end
`ifdef SINGLE_STEP_EN
            ST_STEPWAIT: state_nxt = step_rise ? ST_FETCH : ST_STEPWAIT;
`endif
            default: state_nxt = ST_START;
        endcase
    end

    assign bus.IRload  = irload;
    assign bus.PCload  = pcload;
    assign bus.JMPmux  = jmpmux;
    assign bus.Meminst = meminst;
    assign bus.MemWr   = memwr;
    assign bus.Aload   = aload;
    assign bus.Asel    = asel;
    assign bus.Sub     = sub;
    assign bus.Halted  = halted;
    assign bus.State   = state;

endmodule
